// File: rtl/scarf_regmap_n_edge_counters_snap_pkg.sv
// Shared address map and helpers for the SCARF edge-counter register map.
package scarf_regmap_pkg;

  localparam int CFG_EN   = 0;
  localparam int CFG_TRIG = 1;
  localparam int CFG_INV  = 2;
  localparam int CFG_TOUT = 3;
  localparam int CLR      = 4;
  localparam int CAP      = 5;
  localparam int CNT_BASE = 8;
  localparam int NUM_CFG  = 4;

  // Byte address of byte b of counter k in channel ch.
  function automatic int cnt_addr(input int ch, input int k, input int b,
                                  input int num_cnt, input int cnt_bytes);
    return CNT_BASE + (ch * num_cnt + k) * cnt_bytes + b;
  endfunction

endpackage

// File: rtl/scarf_regmap_n_edge_counters_snap_byte_ptr.sv
// Transaction byte pointer: tracks the address byte, auto-increment and end-of-map blocking.
module scarf_byte_ptr #(
  parameter int ADDR_W   = 6,
  parameter int MAX_ADDR = 31,
  parameter int WRAP_EN  = 0
) (
  input  logic              clk,
  input  logic              rst_n_sync,
  input  logic              byte_valid,
  input  logic              finished,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              first_byte,
  output logic [ADDR_W-1:0] address,
  output logic              final_byte
);

  localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_ADDR);

  logic              first_byte_q, first_byte_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              final_byte_q, final_byte_d;

  always_comb begin
    first_byte_d = first_byte_q;
    address_d    = address_q;
    final_byte_d = final_byte_q;
    // End of transaction wins over a byte arriving in the same clk.
    if (finished) begin
      first_byte_d = 1'b1;
      address_d    = '0;
      final_byte_d = 1'b0;
    end else if (byte_valid) begin
      if (first_byte_q) begin
        first_byte_d = 1'b0;
        address_d    = addr_in;
      end else if (address_q == MAX_A) begin
        if (WRAP_EN != 0) address_d = '0;
        else final_byte_d = 1'b1;
      end else begin
        address_d = address_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      first_byte_q <= 1'b1;
      address_q    <= '0;
      final_byte_q <= 1'b0;
    end else begin
      first_byte_q <= first_byte_d;
      address_q    <= address_d;
      final_byte_q <= final_byte_d;
    end
  end

  assign first_byte = first_byte_q;
  assign address    = address_q;
  assign final_byte = final_byte_q;

endmodule

// File: rtl/scarf_regmap_n_edge_counters_snap.sv
// SCARF slave register map: config regs, channel clear pulses, capability byte and
// coherent counter snapshots taken at the address byte of every read.
module scarf_regmap_n_edge_counters_snap
  import scarf_regmap_pkg::*;
#(
  parameter logic [6:0] SLAVE_ID  = 7'h03,
  parameter int         NUM_CH    = 2,
  parameter int         NUM_CNT   = 3,
  parameter int         CNT_BYTES = 4,
  parameter int         NUM_IN    = 4,
  parameter int         ADDR_W    = 6,
  parameter int         WRAP_EN   = 0
) (
  input  logic                                  clk,
  input  logic                                  rst_n_sync,
  input  logic [7:0]                            data_in,
  input  logic                                  data_in_valid,
  input  logic                                  data_in_finished,
  input  logic [6:0]                            slave_id,
  input  logic                                  rnw,
  output logic [7:0]                            read_data_out,
  output logic [NUM_IN-1:0]                     enable,
  output logic [NUM_IN-1:0]                     trig_enable,
  output logic [NUM_IN-1:0]                     cfg_in_inv,
  output logic [NUM_IN-1:0]                     cfg_trig_out,
  output logic [NUM_CH-1:0]                     clear_counts,
  input  logic [NUM_CH*NUM_CNT*CNT_BYTES*8-1:0] count_in
);

  localparam int SNAP_BYTES = NUM_CH * NUM_CNT * CNT_BYTES;
  localparam int MAX_ADDR   = cnt_addr(NUM_CH - 1, NUM_CNT - 1, CNT_BYTES - 1, NUM_CNT, CNT_BYTES);

  logic              valid_slave;
  logic              first_byte;
  logic              final_byte;
  logic [ADDR_W-1:0] address;
  logic              take_snap;
  logic              wr_en;
  logic [7:0]        rd_byte;
  logic              unused_data_bits;

  logic [SNAP_BYTES-1:0][7:0]     snap_q, snap_d;
  logic [NUM_CFG-1:0][NUM_IN-1:0] cfg_q, cfg_d;
  logic [NUM_CH-1:0]              clear_q, clear_d;

  assign valid_slave      = (slave_id == SLAVE_ID);
  assign take_snap        = valid_slave && rnw && first_byte && data_in_valid;
  assign wr_en            = valid_slave && !rnw && data_in_valid && !first_byte && !final_byte;
  assign unused_data_bits = &{1'b0, data_in[7:ADDR_W]};

  scarf_byte_ptr #(
    .ADDR_W   (ADDR_W),
    .MAX_ADDR (MAX_ADDR),
    .WRAP_EN  (WRAP_EN)
  ) u_byte_ptr (
    .clk        (clk),
    .rst_n_sync (rst_n_sync),
    .byte_valid (data_in_valid && valid_slave),
    .finished   (data_in_finished),
    .addr_in    (data_in[ADDR_W-1:0]),
    .first_byte (first_byte),
    .address    (address),
    .final_byte (final_byte)
  );

  always_comb begin
    snap_d  = take_snap ? count_in : snap_q;
    cfg_d   = cfg_q;
    clear_d = '0;
    if (wr_en) begin
      for (int i = 0; i < NUM_CFG; i++) begin
        if (address == ADDR_W'(i)) cfg_d[i] = data_in[NUM_IN-1:0];
      end
      if (address == ADDR_W'(CLR)) clear_d = data_in[NUM_CH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      snap_q  <= '0;
      cfg_q   <= '0;
      clear_q <= '0;
    end else begin
      snap_q  <= snap_d;
      cfg_q   <= cfg_d;
      clear_q <= clear_d;
    end
  end

  // Unmatched addresses (CLR, reserved, past MAX_ADDR) fall through to 0.
  always_comb begin
    rd_byte = 8'h00;
    for (int i = 0; i < NUM_CFG; i++) begin
      if (address == ADDR_W'(i)) rd_byte = 8'(cfg_q[i]);
    end
    if (address == ADDR_W'(CAP)) rd_byte = {4'(NUM_CNT), 4'(NUM_CH)};
    for (int i = 0; i < SNAP_BYTES; i++) begin
      if (address == ADDR_W'(CNT_BASE + i)) rd_byte = snap_q[i];
    end
  end

  always_comb begin
    read_data_out = 8'h00;
    if (valid_slave && rnw) begin
      if (first_byte)       read_data_out = {1'b0, SLAVE_ID};
      else if (!final_byte) read_data_out = rd_byte;
    end
  end

  assign enable       = cfg_q[CFG_EN];
  assign trig_enable  = cfg_q[CFG_TRIG];
  assign cfg_in_inv   = cfg_q[CFG_INV];
  assign cfg_trig_out = cfg_q[CFG_TOUT];
  assign clear_counts = clear_q;

endmodule

// File: tb/tb_scarf_regmap_n_edge_counters_snap.sv
// Scoreboard bench: two maps (saturating and wrapping) share one SCARF byte stream.
module tb_scarf_regmap_n_edge_counters_snap;
  import scarf_regmap_pkg::*;

  localparam int K_RD0 = 0, K_RD1 = 1, K_EN0 = 2, K_TRIG0 = 3, K_INV0 = 4,
                 K_TOUT0 = 5, K_CLR0 = 6, K_EN1 = 7, K_CLR1 = 8;

  logic         clk = 1'b0;
  logic         rst_n_sync;
  logic [7:0]   data_in;
  logic         data_in_valid;
  logic         data_in_finished;
  logic [6:0]   slave_id;
  logic         rnw;
  logic [191:0] count_in;
  logic [7:0]   rd0, rd1;
  logic [3:0]   en0, trig0, inv0, tout0, en1, trig1, inv1, tout1;
  logic [1:0]   clr0, clr1;
  logic         stb;

  typedef struct {
    int         kind;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  scarf_regmap_n_edge_counters_snap #(.WRAP_EN(0)) u_dut0 (
    .clk(clk), .rst_n_sync(rst_n_sync), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_finished(data_in_finished), .slave_id(slave_id), .rnw(rnw),
    .read_data_out(rd0), .enable(en0), .trig_enable(trig0), .cfg_in_inv(inv0),
    .cfg_trig_out(tout0), .clear_counts(clr0), .count_in(count_in));

  scarf_regmap_n_edge_counters_snap #(.WRAP_EN(1)) u_dut1 (
    .clk(clk), .rst_n_sync(rst_n_sync), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_finished(data_in_finished), .slave_id(slave_id), .rnw(rnw),
    .read_data_out(rd1), .enable(en1), .trig_enable(trig1), .cfg_in_inv(inv1),
    .cfg_trig_out(tout1), .clear_counts(clr1), .count_in(count_in));

  function automatic logic [7:0] actual(input int k);
    case (k)
      K_RD0:   return rd0;
      K_RD1:   return rd1;
      K_EN0:   return {4'h0, en0};
      K_TRIG0: return {4'h0, trig0};
      K_INV0:  return {4'h0, inv0};
      K_TOUT0: return {4'h0, tout0};
      K_CLR0:  return {6'h0, clr0};
      K_EN1:   return {4'h0, en1};
      K_CLR1:  return {6'h0, clr1};
      default: return 8'hxx;
    endcase
  endfunction

  // Monitor: every strobed cycle drains the expectations queued for it.
  always @(negedge clk) begin
    if (stb) begin
      while (sb_q.size() > 0) begin
        exp_t e;
        logic [7:0] a;
        e = sb_q.pop_front();
        a = actual(e.kind);
        n_tests++;
        if (a !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %02h expected %02h", e.name, a, e.exp);
        end
      end
    end
  end

  task automatic push(input int k, input logic [7:0] v, input string n);
    exp_t e;
    e.kind = k;
    e.exp  = v;
    e.name = n;
    sb_q.push_back(e);
  endtask

  task automatic xfer(input logic [7:0] d, input logic s);
    data_in       = d;
    data_in_valid = 1'b1;
    stb           = s;
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    data_in       = 8'h00;
    stb           = 1'b0;
  endtask

  task automatic chk();
    stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0;
  endtask

  task automatic fin();
    data_in_finished = 1'b1;
    @(posedge clk); #1;
    data_in_finished = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic set_cnt(input int ch, input int k, input logic [31:0] v);
    count_in[(ch*3+k)*32 +: 32] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_sync = 1'b0; data_in = 8'h00; data_in_valid = 1'b0; data_in_finished = 1'b0;
    slave_id = 7'h03; rnw = 1'b0; count_in = '0; stb = 1'b0;
    repeat (3) @(posedge clk); #1;

    push(K_EN0, 8'h00, "rst_enable"); push(K_CLR0, 8'h00, "rst_clear");
    push(K_RD0, 8'h00, "rst_read"); push(K_TOUT0, 8'h00, "rst_tout");
    chk();
    rst_n_sync = 1'b1;
    @(posedge clk); #1;

    // Config write burst from address 0
    rnw = 1'b0;
    xfer(8'h00, 0); xfer(8'h0F, 0); xfer(8'hA5, 0); xfer(8'h03, 0); xfer(8'h0C, 0);
    fin();
    push(K_EN0, 8'h0F, "cfg_enable"); push(K_TRIG0, 8'h05, "cfg_trig");
    push(K_INV0, 8'h03, "cfg_inv"); push(K_TOUT0, 8'h0C, "cfg_tout");
    push(K_EN1, 8'h0F, "cfg_enable_wrap");
    chk();

    // Readback, slave id on the address byte
    rnw = 1'b1;
    push(K_RD0, 8'h03, "rd_slave_id"); xfer(8'h00, 1);
    push(K_RD0, 8'h0F, "rd_cfg0"); xfer(8'h00, 1);
    push(K_RD0, 8'h05, "rd_cfg1"); xfer(8'h00, 1);
    push(K_RD0, 8'h03, "rd_cfg2"); xfer(8'h00, 1);
    push(K_RD0, 8'h0C, "rd_cfg3"); xfer(8'h00, 1);
    fin();

    // CAP and reserved
    xfer(8'(CAP), 0);
    push(K_RD0, 8'h32, "rd_cap"); xfer(8'h00, 1);
    push(K_RD0, 8'h00, "rd_rsvd6"); xfer(8'h00, 1);
    push(K_RD0, 8'h00, "rd_rsvd7"); xfer(8'h00, 1);
    fin();

    // Snapshot coherence
    set_cnt(0, 0, 32'h0000_00FF);
    xfer(8'(cnt_addr(0, 0, 0, 3, 4)), 0);
    set_cnt(0, 0, 32'h0000_0100);
    push(K_RD0, 8'hFF, "snap_b0"); xfer(8'h00, 1);
    push(K_RD0, 8'h00, "snap_b1"); xfer(8'h00, 1);
    push(K_RD0, 8'h00, "snap_b2"); xfer(8'h00, 1);
    push(K_RD0, 8'h00, "snap_b3"); xfer(8'h00, 1);
    fin();
    xfer(8'(cnt_addr(0, 0, 0, 3, 4)), 0);
    push(K_RD0, 8'h00, "snap2_b0"); xfer(8'h00, 1);
    push(K_RD0, 8'h01, "snap2_b1"); xfer(8'h00, 1);
    push(K_RD0, 8'h00, "snap2_b2"); xfer(8'h00, 1);
    push(K_RD0, 8'h00, "snap2_b3"); xfer(8'h00, 1);
    fin();

    // Clear pulse
    rnw = 1'b0;
    xfer(8'(CLR), 0); xfer(8'h02, 0);
    push(K_CLR0, 8'h02, "clear_pulse"); push(K_CLR1, 8'h02, "clear_pulse_wrap");
    chk();
    push(K_CLR0, 8'h00, "clear_end");
    chk();
    fin();
    rnw = 1'b1;
    xfer(8'(CLR), 0);
    push(K_RD0, 8'h00, "rd_clr_reg"); xfer(8'h00, 1);
    fin();

    // End-of-map: saturate vs wrap
    set_cnt(1, 2, 32'hDEAD_BEEF);
    xfer(8'h1E, 0);
    push(K_RD0, 8'hAD, "end_a30"); push(K_RD1, 8'hAD, "wrap_a30"); xfer(8'h00, 1);
    push(K_RD0, 8'hDE, "end_a31"); push(K_RD1, 8'hDE, "wrap_a31"); xfer(8'h00, 1);
    push(K_RD0, 8'h00, "end_blk0"); push(K_RD1, 8'h0F, "wrap_a0"); xfer(8'h00, 1);
    push(K_RD0, 8'h00, "end_blk1"); push(K_RD1, 8'h05, "wrap_a1"); xfer(8'h00, 1);
    fin();

    // Foreign slave id must not write
    slave_id = 7'h05; rnw = 1'b0;
    xfer(8'h00, 0); xfer(8'h01, 0); xfer(8'h00, 0);
    fin();
    slave_id = 7'h03;
    push(K_EN0, 8'h0F, "foreign_enable"); push(K_TRIG0, 8'h05, "foreign_trig");
    push(K_EN1, 8'h0F, "foreign_enable_wrap");
    chk();

    // Write starting at MAX_ADDR: blocked when saturating, lands on reg 0 when wrapping
    xfer(8'h1F, 0); xfer(8'h11, 0); xfer(8'h07, 0);
    fin();
    push(K_EN0, 8'h0F, "blocked_enable"); push(K_EN1, 8'h07, "wrapped_enable");
    chk();

    // Reset in the middle of a read
    rnw = 1'b1;
    xfer(8'h08, 0); xfer(8'h00, 0);
    rst_n_sync = 1'b0;
    #1;
    push(K_EN0, 8'h00, "midrst_enable"); push(K_TRIG0, 8'h00, "midrst_trig");
    push(K_EN1, 8'h00, "midrst_enable_wrap"); push(K_CLR0, 8'h00, "midrst_clear");
    push(K_RD0, 8'h03, "midrst_first_byte");
    chk();
    rst_n_sync = 1'b1;
    fin();

    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
